pipe_stage_reg_skid: RTL and testbench
======================================

Name: pipe_stage_reg_skid

Overview:
- Parametrised N-lane inter-stage pipeline register for the multi-issue pipeline, for example between EX and MEM.
- Adds a one-entry skid buffer, so the upstream allowin is registered and never combinationally depends on downstream ready.
- Per-lane valid bits; separate exception flush and branch flush semantics; saturating backpressure-stall counter for performance monitoring.

Parameters:
- LANES, 2, number of issue lanes (≥1).
- DW, 64, bus width per lane, in bits.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid_i  in  LANES  per-lane valid from the previous stage.
- in_data_i  in  LANES*DW  lane k occupies bits [k*DW +: DW].
- in_allowin_o  out  1  this stage can accept a beat (registered).
- out_valid_o  out  LANES  per-lane valid to the next stage.
- out_data_o  out  LANES*DW  main-entry data.
- out_ready_i  in  1  next-stage allowin.
- excep_flush_i  in  1  kill all contents.
- branch_flush_i  in  1  kill younger-than-main contents.
- stall_cnt_o  out  CNT_W  count of cycles in which a valid main entry was blocked.

Behaviour:
- Storage:
  - main entry: m_valid[LANES], m_data.
  - skid entry: s_valid[LANES], s_data, s_full.
  - m_any = |m_valid.
- Derived signals:
  - in_allowin_o = ~s_full, read directly from a flop.
  - xfer = (|in_valid_i) & in_allowin_o.
  - adv = m_any & out_ready_i.
  - m_load = ~m_any | out_ready_i.
- Reset (rst_n=0 at clk edge):
  - m_valid=0, s_valid=0, s_full=0.
  - m_data=0, s_data=0.
  - stall_cnt=0.
  - in_allowin_o=1 from the first cycle after reset.
  - Reset mid-operation discards everything.
- Priority per cycle: reset > excep_flush > branch_flush > normal.
- excep_flush_i=1:
  - m_valid=0, s_valid=0, s_full=0 next cycle.
  - Data registers hold.
  - Input beat discarded.
  - stall_cnt updates normally.
- branch_flush_i=1 (excep_flush_i=0):
  - Skid entry and this cycle's input beat are discarded; s_full=0 next cycle.
  - Main entry is older and is kept if not advancing.
  - If adv=1, main becomes invalid.
- Normal operation:
  - m_load & s_full: main<=skid. If xfer, skid<=input; else s_full<=0.
  - m_load & ~s_full: if xfer, main<=input; else m_valid<=0 and m_data holds.
  - ~m_load & xfer: skid<=input, s_full<=1. Skid is guaranteed empty here because allowin was 1.
  - ~m_load & ~xfer: hold.
- Lane handling:
  - Data for all lanes is captured on any load, regardless of individual lane valids.
  - Invalid lanes carry don't-care data.
  - Lane valids of a beat move together; no lane reordering.
- Throughput and latency:
  - 1 beat/cycle when out_ready_i is continuously high.
  - Input at edge t appears on out_* after edge t (1-cycle latency).
- Backpressure:
  - Skid absorbs exactly one beat.
  - in_allowin_o drops in the cycle after the skid fills.
  - in_allowin_o rises in the cycle after the skid drains into main.
- stall_cnt: increments when m_any & ~out_ready_i; saturates at 2^CNT_W−1 with no wrap; not cleared by flushes.
- out_valid_o=m_valid and out_data_o=m_data, both purely registered.
- Lanes with in_valid_i=0 never become valid, even if another lane loads.

Decomposition:
- Shared package/header holds:
  - lane bus width macros (per-stage DW constants);
  - RstEnable;
  - flush-priority encoding.
- One natural sub-module: pipe_entry_reg, a single entry of per-lane valid plus data with load/clear/hold.
  - Instantiate it twice (main, skid).
  - Top level holds the control logic and the counter.

Test Plan:
- Streaming: LANES=2, out_ready=1, beats A(valid=11), B(10), C(01) on consecutive cycles.
  - out_valid = 11, 10, 01 one cycle later.
  - in_allowin stays 1; stall_cnt=0.
- Skid fill: hold out_ready=0 and present A then B.
  - Main=A, skid=B; in_allowin=0 from the cycle after B.
  - Raise out_ready: out shows A then B; allowin returns to 1 one cycle after B moves to main.
  - stall_cnt = number of blocked cycles (e.g. 3).
- Exception flush: main=A, skid=B, input C valid, excep_flush=1 for one cycle.
  - Next cycle out_valid=00, s_full=0, in_allowin=1; C never appears.
- Branch flush without advance: main=A, skid=B, out_ready=0, branch_flush=1.
  - A retained (out_valid=11); B dropped; in_allowin=1 next cycle.
- Branch flush with advance: same setup with out_ready=1; next cycle out_valid=00.
- Saturation and reset: CNT_W=4, stall for 20 cycles → stall_cnt=15.
  - Assert rst_n=0 mid-stream → all valids 0, stall_cnt=0, in_allowin=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg_skid_pkg.sv
// Shared constants and types for the inter-stage skid pipeline register.
// Holds the per-stage lane widths, the reset level and the flush-priority encoding.
package pipe_stage_reg_skid_pkg;

  localparam int ID_EX_DW  = 64;
  localparam int EX_MEM_DW = 64;
  localparam int MEM_WB_DW = 64;

  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    FLUSH_NONE   = 2'd0,
    FLUSH_BRANCH = 2'd1,
    FLUSH_EXCEP  = 2'd2
  } flush_t;

  // An exception flush outranks a branch flush in the same cycle.
  function automatic flush_t flush_sel(input logic excep, input logic branch);
    if (excep)       return FLUSH_EXCEP;
    else if (branch) return FLUSH_BRANCH;
    else             return FLUSH_NONE;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: per-lane valid bits plus the full lane data bus.
// Load captures valid and data; clear drops the valids only, so the data holds.
module pipe_entry_reg
  import pipe_stage_reg_skid_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clr,
  input  logic [LANES-1:0]      ld_valid,
  input  logic [LANES*DW-1:0]   ld_data,
  output logic [LANES-1:0]      valid,
  output logic [LANES*DW-1:0]   data
);

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      valid <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= ld_valid;
      data  <= ld_data;
    end else if (clr) begin
      valid <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg_skid.sv
// N-lane inter-stage pipeline register with a one-entry skid buffer, so allowin
// is a flop output; supports exception/branch flushes and a saturating stall counter.
module pipe_stage_reg_skid
  import pipe_stage_reg_skid_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = EX_MEM_DW,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      in_valid_i,
  input  logic [LANES*DW-1:0]   in_data_i,
  output logic                  in_allowin_o,
  output logic [LANES-1:0]      out_valid_o,
  output logic [LANES*DW-1:0]   out_data_o,
  input  logic                  out_ready_i,
  input  logic                  excep_flush_i,
  input  logic                  branch_flush_i,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [LANES-1:0]    m_valid, s_valid, m_ld_valid;
  logic [LANES*DW-1:0] m_data, s_data, m_ld_data;
  logic                allowin_q, s_full, s_full_nxt;
  logic                m_any, xfer, adv, m_load;
  logic                m_ld, m_from_skid, m_clr, s_ld, s_clr;
  logic [CNT_W-1:0]    stall_q;

  // The skid occupancy is kept inverted so the upstream allowin is a bare flop.
  assign s_full = ~allowin_q;
  assign m_any  = |m_valid;
  assign xfer   = (|in_valid_i) & allowin_q;
  assign adv    = m_any & out_ready_i;
  assign m_load = ~m_any | out_ready_i;

  always_comb begin
    m_ld        = 1'b0;
    m_from_skid = 1'b0;
    m_clr       = 1'b0;
    s_ld        = 1'b0;
    s_clr       = 1'b0;
    s_full_nxt  = s_full;
    unique case (flush_sel(excep_flush_i, branch_flush_i))
      FLUSH_EXCEP: begin
        m_clr      = 1'b1;
        s_clr      = 1'b1;
        s_full_nxt = 1'b0;
      end
      FLUSH_BRANCH: begin
        m_clr      = adv;
        s_clr      = 1'b1;
        s_full_nxt = 1'b0;
      end
      default: begin
        if (m_load && s_full) begin
          m_ld        = 1'b1;
          m_from_skid = 1'b1;
          if (xfer) s_ld = 1'b1;
          else begin
            s_clr      = 1'b1;
            s_full_nxt = 1'b0;
          end
        end else if (m_load) begin
          if (xfer) m_ld = 1'b1;
          else      m_clr = 1'b1;
        end else if (xfer) begin
          s_ld       = 1'b1;
          s_full_nxt = 1'b1;
        end
      end
    endcase
  end

  assign m_ld_valid = m_from_skid ? s_valid : in_valid_i;
  assign m_ld_data  = m_from_skid ? s_data  : in_data_i;

  pipe_entry_reg #(.LANES(LANES), .DW(DW)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (m_ld),
    .clr      (m_clr),
    .ld_valid (m_ld_valid),
    .ld_data  (m_ld_data),
    .valid    (m_valid),
    .data     (m_data)
  );

  pipe_entry_reg #(.LANES(LANES), .DW(DW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (s_ld),
    .clr      (s_clr),
    .ld_valid (in_valid_i),
    .ld_data  (in_data_i),
    .valid    (s_valid),
    .data     (s_data)
  );

  // Stall counting looks at the current main entry, independent of any flush.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      allowin_q <= 1'b1;
      stall_q   <= '0;
    end else begin
      allowin_q <= ~s_full_nxt;
      if (m_any && !out_ready_i) stall_q <= sat_inc(stall_q);
    end
  end

  assign in_allowin_o = allowin_q;
  assign out_valid_o  = m_valid;
  assign out_data_o   = m_data;
  assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg_skid.sv
// Bench for pipe_stage_reg_skid: directed scenarios then random traffic, checked
// against a two-deep FIFO model of the stage's contents.
module tb_pipe_stage_reg_skid;

  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int CNT_W = 4;
  localparam int BW    = LANES * DW;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LANES-1:0] in_valid;
  logic [BW-1:0]    in_data;
  logic             in_allowin;
  logic [LANES-1:0] out_valid;
  logic [BW-1:0]    out_data;
  logic             out_ready;
  logic             excep_flush;
  logic             branch_flush;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg_skid #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_allowin_o   (in_allowin),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_ready_i    (out_ready),
    .excep_flush_i  (excep_flush),
    .branch_flush_i (branch_flush),
    .stall_cnt_o    (stall_cnt)
  );

  typedef struct packed {
    logic [LANES-1:0] v;
    logic [BW-1:0]    d;
  } beat_t;

  beat_t q[$];
  int    exp_cnt;
  int    checks;
  int    errors;

  localparam logic [BW-1:0] DA = 32'hA1A1_A0A0;
  localparam logic [BW-1:0] DB = 32'hB1B1_B0B0;
  localparam logic [BW-1:0] DC = 32'hC1C1_C0C0;

  // Stage contents are an in-order queue of at most two beats.
  task automatic model_edge();
    int sz;
    sz = q.size();
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      return;
    end
    if (sz > 0 && !out_ready && exp_cnt < CMAX) exp_cnt++;
    if (excep_flush) begin
      q.delete();
    end else if (branch_flush) begin
      if (sz > 0 && out_ready) q.delete();
      else while (q.size() > 1) void'(q.pop_back());
    end else begin
      if (sz > 0 && out_ready) void'(q.pop_front());
      if ((|in_valid) && sz < 2) q.push_back('{v: in_valid, d: in_data});
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check("valid", 64'(out_valid), (q.size() > 0) ? 64'(q[0].v) : 64'd0);
    if (q.size() > 0) check("data", 64'(out_data), 64'(q[0].d));
    check("allowin", 64'(in_allowin), (q.size() < 2) ? 64'd1 : 64'd0);
    check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic [LANES-1:0] v, input logic [BW-1:0] d,
                       input logic rdy, input logic ex, input logic br);
    in_valid     = v;
    in_data      = d;
    out_ready    = rdy;
    excep_flush  = ex;
    branch_flush = br;
  endtask

  task automatic fill_ab();
    drive(2'b11, DA, 1'b0, 1'b0, 1'b0); cyc();
    drive(2'b11, DB, 1'b0, 1'b0, 1'b0); cyc();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    drive(2'b00, '0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_allowin", 64'(in_allowin), 64'd1);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;

    // Streaming
    drive(2'b11, DA, 1'b1, 1'b0, 1'b0); cyc();
    check("stream_a", 64'(out_valid), 64'h3);
    drive(2'b10, DB, 1'b1, 1'b0, 1'b0); cyc();
    check("stream_b", 64'(out_valid), 64'h2);
    drive(2'b01, DC, 1'b1, 1'b0, 1'b0); cyc();
    check("stream_c", 64'(out_valid), 64'h1);
    check("stream_data", 64'(out_data), 64'(DC));
    check("stream_allowin", 64'(in_allowin), 64'd1);
    drive(2'b00, '0, 1'b1, 1'b0, 1'b0); cyc();
    check("stream_cnt", 64'(stall_cnt), 64'd0);

    // Skid fill and drain
    fill_ab();
    check("skid_allowin_low", 64'(in_allowin), 64'd0);
    drive(2'b11, DC, 1'b0, 1'b0, 1'b0); cyc();
    check("skid_hold_a", 64'(out_data), 64'(DA));
    drive(2'b00, '0, 1'b1, 1'b0, 1'b0); cyc();
    check("skid_out_b", 64'(out_data), 64'(DB));
    check("skid_allowin_back", 64'(in_allowin), 64'd1);
    check("skid_cnt", 64'(stall_cnt), 64'd2);
    cyc();
    check("skid_empty", 64'(out_valid), 64'd0);

    // Exception flush
    fill_ab();
    drive(2'b11, DC, 1'b0, 1'b1, 1'b0); cyc();
    check("excep_valid", 64'(out_valid), 64'd0);
    check("excep_allowin", 64'(in_allowin), 64'd1);
    drive(2'b00, '0, 1'b1, 1'b0, 1'b0); cyc();
    check("excep_no_c", 64'(out_valid), 64'd0);

    // Branch flush, main not advancing
    fill_ab();
    drive(2'b11, DC, 1'b0, 1'b0, 1'b1); cyc();
    check("br_keep_a", 64'(out_valid), 64'h3);
    check("br_keep_data", 64'(out_data), 64'(DA));
    check("br_allowin", 64'(in_allowin), 64'd1);
    drive(2'b00, '0, 1'b1, 1'b0, 1'b0); cyc();
    check("br_b_dropped", 64'(out_valid), 64'd0);

    // Branch flush with main advancing
    fill_ab();
    drive(2'b11, DC, 1'b1, 1'b0, 1'b1); cyc();
    check("br_adv_valid", 64'(out_valid), 64'd0);
    drive(2'b00, '0, 1'b1, 1'b0, 1'b0); cyc();

    // Saturation, then reset mid-stream
    drive(2'b01, DA, 1'b0, 1'b0, 1'b0); cyc();
    drive(2'b00, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc();
    check("sat_cnt", 64'(stall_cnt), 64'(CMAX));
    drive(2'b11, DB, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    drive(2'b00, '0, 1'b0, 1'b0, 1'b0); cyc();
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_cnt", 64'(stall_cnt), 64'd0);
    check("rst2_allowin", 64'(in_allowin), 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      drive(LANES'($urandom), BW'($urandom),
            ($urandom_range(9) < 6) ? 1'b1 : 1'b0,
            ($urandom_range(31) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(19) == 0) ? 1'b1 : 1'b0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
